// File: rtl/uart_echo_system.sv
// 8N1 UART transmitter looped back internally into an 8N1 receiver, with a
// registered read port and an independent enabled 5-to-32 one-hot decoder.
module uart_echo_system #(
    parameter int clk_freq = 50_000_000,
    parameter int baud     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  denv,
    input  logic        wr,
    input  logic        rd,
    output logic [7:0]  drec,
    input  logic        habilitarDecodificador,
    input  logic [4:0]  entradaDecodificador,
    output logic [31:0] salidaDecodificador
);

    localparam int DIV = clk_freq / baud;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((DIV / 2 > 0) ? (DIV / 2 - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    uart_state_t tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          txd;

    uart_state_t rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_done;

    logic [7:0] hold;
    logic       avail;

    // Transmitter: the frame is shifted out of tx_shift LSB first; txd is registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= '0;
                    tx_bit <= '0;
                    if (wr) begin
                        tx_shift <= denv;
                        txd      <= 1'b0;
                        tx_state <= S_START;
                    end else begin
                        txd <= 1'b1;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            txd    <= tx_shift[1];
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    txd <= 1'b1;
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    txd      <= 1'b1;
                end
            endcase
        end
    end

    // Receiver: half-bit wait after the falling edge, then one sample per bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (!txd) begin
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= txd ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {txd, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    rx_state <= S_IDLE;
                end
            endcase
        end
    end

    // A frame is accepted only when the stop-bit sample is high.
    always_comb begin
        rx_done = 1'b0;
        if (rx_state == S_STOP && rx_cnt == BIT_LAST && txd) begin
            rx_done = 1'b1;
        end
    end

    // Holding register and read port; a completing frame wins over a pending read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold  <= '0;
            avail <= 1'b0;
            drec  <= '0;
        end else if (rx_done) begin
            hold <= rx_shift;
            if (rd) begin
                drec  <= rx_shift;
                avail <= 1'b0;
            end else begin
                avail <= 1'b1;
            end
        end else if (rd && avail) begin
            drec  <= hold;
            avail <= 1'b0;
        end
    end

    always_comb begin
        salidaDecodificador = '0;
        if (habilitarDecodificador) begin
            salidaDecodificador = 32'd1 << entradaDecodificador;
        end
    end

endmodule

// File: tb/tb_uart_echo_system.sv
// Randomized loopback bench for uart_echo_system against a transaction-level model.
module tb_uart_echo_system;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * DIV;
    localparam int RX_LAT   = 1 + (19 * DIV) / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  denv;
    logic        wr;
    logic        rd;
    logic [7:0]  drec;
    logic        en;
    logic [4:0]  sel;
    logic [31:0] dec;

    uart_echo_system #(.clk_freq(CLK_FREQ), .baud(BAUD)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .denv                  (denv),
        .wr                    (wr),
        .rd                    (rd),
        .drec                  (drec),
        .habilitarDecodificador(en),
        .entradaDecodificador  (sel),
        .salidaDecodificador   (dec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: byte-level view of the loopback link.
    int         tx_free = 0;
    int         pend_t[$];
    logic [7:0] pend_b[$];
    logic [7:0] m_hold  = 8'h00;
    logic [7:0] m_drec  = 8'h00;
    bit         m_avail = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        bit         arrived;
        logic [7:0] b;
        @(posedge clk);
        #1;
        arrived = 1'b0;
        b = 8'h00;
        if (!rst) begin
            tx_free = 0;
            pend_t.delete();
            pend_b.delete();
            m_hold  = 8'h00;
            m_drec  = 8'h00;
            m_avail = 1'b0;
        end else begin
            if (wr && cyc >= tx_free) begin
                tx_free = cyc + FRAME + 1;
                pend_t.push_back(cyc + RX_LAT);
                pend_b.push_back(denv);
            end
            while (pend_t.size() > 0 && pend_t[0] <= cyc) begin
                arrived = 1'b1;
                b = pend_b[0];
                void'(pend_t.pop_front());
                void'(pend_b.pop_front());
            end
            if (arrived) begin
                m_hold = b;
                if (rd) begin
                    m_drec  = b;
                    m_avail = 1'b0;
                end else begin
                    m_avail = 1'b1;
                end
            end else if (rd && m_avail) begin
                m_drec  = m_hold;
                m_avail = 1'b0;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b, output int e);
        denv = b;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        e = cyc;
    endtask

    task automatic read();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic settle();
        while (cyc < tx_free + 2) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int e2;
        int lat;
        int off;
        int nr;
        bit got_avail;
        logic [7:0] b;

        rst = 1'b0; wr = 1'b0; rd = 1'b0; denv = 8'h00; en = 1'b0; sel = 5'd0;
        ticks(3);
        rst = 1'b1;
        tick();
        chk("reset_drec", 32'(drec), 32'h00);
        chk("reset_txd", 32'(dut.txd), 32'd1);
        chk("reset_avail", 32'(dut.avail), 32'd0);

        send(8'h55, e);
        ticks(FRAME + 10);
        read();
        chk("echo_55", 32'(drec), 32'h55);
        read();
        chk("echo_55_reread", 32'(drec), 32'h55);

        send(8'hA5, e);
        ticks(100);
        send(8'h3C, e2);
        settle();
        read();
        chk("busy_first_kept", 32'(drec), 32'hA5);
        chk("busy_no_second", 32'(dut.avail), 32'd0);
        read();
        chk("busy_reread", 32'(drec), 32'hA5);

        send(8'hC3, e);
        got_avail = 1'b0;
        lat = 0;
        for (int k = 0; k < 12 * DIV && !got_avail; k++) begin
            tick();
            if (dut.avail) begin
                got_avail = 1'b1;
                lat = cyc - e;
            end
        end
        chk("avail_seen", 32'(got_avail), 32'd1);
        chk("avail_latency_in_window", 32'(lat >= RX_LAT - 2 && lat <= RX_LAT + 2), 32'd1);
        settle();
        read();
        chk("echo_C3", 32'(drec), 32'hC3);

        send(8'h9E, e);
        while (cyc < e + RX_LAT - 8) tick();
        rd = 1'b1;
        ticks(16);
        rd = 1'b0;
        chk("rd_at_completion", 32'(drec), 32'h9E);
        chk("rd_at_completion_avail", 32'(dut.avail), 32'd0);

        send(8'h12, e);
        settle();
        send(8'h34, e);
        settle();
        read();
        chk("overrun_newest", 32'(drec), 32'h34);

        send(8'h5A, e);
        while (cyc < e + FRAME) tick();
        send(8'h77, e2);
        settle();
        read();
        chk("b2b_min_spacing", 32'(drec), 32'h77);

        send(8'h6B, e);
        while (cyc < e + FRAME - 1) tick();
        send(8'h99, e2);
        settle();
        read();
        chk("b2b_too_early", 32'(drec), 32'h6B);
        chk("b2b_too_early_avail", 32'(dut.avail), 32'd0);

        send(8'hF0, e);
        ticks(3 * DIV);
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
        ticks(12 * DIV);
        read();
        chk("reset_midframe_drec", 32'(drec), 32'h00);
        chk("reset_midframe_avail", 32'(dut.avail), 32'd0);

        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sel = 5'($urandom_range(0, 31));
            #1;
            chk("dec_disabled", dec, 32'h0);
        end
        en = 1'b1;
        sel = 5'd2;  #1; chk("dec_2", dec, 32'h0000_0004);
        sel = 5'd15; #1; chk("dec_15", dec, 32'h0000_8000);
        sel = 5'd31; #1; chk("dec_31", dec, 32'h8000_0000);
        for (int i = 0; i < 32; i++) begin
            sel = 5'(i);
            #1;
            chk("dec_sweep", dec, 32'd1 << i);
        end
        en = 1'b0;

        for (int it = 0; it < 25; it++) begin
            b = 8'($urandom);
            send(b, e);
            if ($urandom_range(0, 1) == 1) begin
                off = $urandom_range(1, FRAME + 1);
                while (cyc < e + off - 1) tick();
                send(8'($urandom), e2);
            end
            settle();
            chk("rand_avail", 32'(dut.avail), 32'(m_avail));
            nr = $urandom_range(0, 2);
            for (int r = 0; r < nr; r++) begin
                read();
                chk("rand_drec", 32'(drec), 32'(m_drec));
            end
        end
        read();
        chk("final_drec", 32'(drec), 32'(m_drec));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_echo_system.md
# uart_echo_system

Top-level echo/test block for the UART I/O bring-up. It holds an 8N1 UART transmitter whose serial line loops back internally into an 8N1 receiver. Bytes written on the parallel send port therefore come back on the parallel receive port. The block also contains an independent 5-to-32 enabled one-hot decoder used for board I/O selection.

## Interface
Parameters:
- `clk_freq`, default 50_000_000: system clock frequency in Hz.
- `baud`, default 115200: serial bit rate. Bit period `DIV = clk_freq / baud` (integer division; 434 at defaults).

Ports:
- `clk`  in  1: single system clock; all state on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `denv`  in  8: byte to transmit.
- `wr`  in  1: write strobe; sampled each clock.
- `rd`  in  1: read strobe; sampled each clock.
- `drec`  out  8: last byte read from the receiver, registered.
- `habilitarDecodificador`  in  1: decoder enable.
- `entradaDecodificador`  in  5: decoder select.
- `salidaDecodificador`  out  32: one-hot decoder output.

## Operation
- Internal serial line `txd`: idle high, 1 in reset. The receiver input is `txd` directly, with no synchronizer.
- **Transmitter FSM** (IDLE, START, DATA, STOP):
  - IDLE and `wr`=1: latch `denv`, go to START.
  - START drives 0 for DIV cycles.
  - DATA drives bits 0..7, LSB first, DIV cycles each.
  - STOP drives 1 for DIV cycles, then IDLE.
  - `wr` in any state other than IDLE is ignored; no queueing.
- **Receiver FSM** (IDLE, START, DATA, STOP):
  - IDLE: detect `txd`=0, go to START.
  - START: after DIV/2 cycles, re-sample. If 0, go to DATA; if 1, glitch, back to IDLE.
  - DATA: sample 8 bits at DIV-cycle intervals, LSB first.
  - STOP: sample once DIV later. If 1, write the byte to the holding register and set `avail`=1. If 0 (framing error), discard the byte and leave `avail` unchanged. Either way, return to IDLE.
- A new frame overwrites the holding register even if `avail` is already set (overrun; newest byte wins).
- **Read port:**
  - `rd`=1 and `avail`=1: on that edge, `drec` ← holding register and `avail` ← 0.
  - `rd`=1 and `avail`=0: `drec` unchanged.
  - Frame completion and `rd` in the same cycle: the new byte is loaded into `drec` and `avail` ends at 0.
- **Decoder:** purely combinational and independent of `clk`/`rst`.
  - `habilitarDecodificador`=1: `salidaDecodificador` = 1 << `entradaDecodificador`.
  - `habilitarDecodificador`=0: all zeros.
- **Reset (`rst`=0):**
  - Both FSMs return to IDLE and all counters clear.
  - `txd`=1, `avail`=0, `drec`=8'h00, holding register 0.
  - Reset mid-frame aborts the frame; no byte is delivered.

## Timing
- `wr` accepted at edge N: `txd` falls at edge N+1; frame lasts 10·DIV cycles; transmitter is back in IDLE at N+1+10·DIV.
- Receiver sets `avail` at about N+1+9.5·DIV (stop-bit sample point); within ±2 cycles is acceptable.
- `drec` updates on the edge where `rd`=1 and `avail`=1 (one-cycle latency from the `rd` sample).
- Back-to-back: a `wr` on the cycle the transmitter re-enters IDLE is accepted; minimum frame spacing is 10·DIV+1 cycles.
- Decoder: output follows inputs combinationally, with no clock latency.

## Test plan
- Reset: assert `rst`=0 for 3 cycles, release → `drec`=8'h00, `txd`=1, transmitter idle.
- Echo: pulse `wr` with `denv`=8'h55, wait 10·DIV+10 cycles, pulse `rd` → `drec`=8'h55. Second `rd` → `drec` stays 8'h55.
- Busy rejection: pulse `wr` with 8'hA5; 100 cycles later pulse `wr` with 8'h3C; wait, then `rd` → `drec`=8'hA5, and no second byte becomes available.
- Reset mid-frame: `wr` 8'hF0, assert `rst` at 3·DIV cycles, release, wait 12·DIV, `rd` → `drec`=8'h00.
- Overrun: send 8'h12, then 8'h34 without reading, then `rd` → `drec`=8'h34.
- Decoder sweep:
  - enable=0, any input → 32'h0.
  - enable=1, input 2 → 32'h00000004.
  - input 15 → 32'h00008000.
  - input 31 → 32'h80000000.
  - sweep 0..31 → exactly one bit set, at the input index.
